// File: rtl/video_timing_gen.sv
// Raster timing source for the RGB interface: DE/HSYNC/VSYNC, pixel coordinates
// and line/frame strobes from compile-time porch, sync and active lengths.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic I_rgb_clk,
  input  logic I_rst,
  input  logic I_enable,
  output logic O_rgb_de,
  output logic O_rgb_hsync,
  output logic O_rgb_vsync,
  output logic [((H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1)-1:0] O_x,
  output logic [((V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1)-1:0] O_y,
  output logic O_line_start,
  output logic O_frame_start,
  output logic O_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
      $error("video_timing_gen: every timing parameter must be at least 1");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            de_q, de_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            busy_q, busy_d;
  logic            run;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (I_enable) state_d = RUN;
      end
      RUN: begin
        // I_enable only matters on the final cycle so a frame is never cut short
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
            if (!I_enable) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
    endcase
  end

  always_comb begin
    run           = (state_q == RUN);
    de_d          = run && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hsync_d       = run && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    vsync_d       = run && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    x_d           = de_d ? h_cnt_q[XW-1:0] : '0;
    y_d           = de_d ? v_cnt_q[YW-1:0] : '0;
    line_start_d  = de_d && (h_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
    busy_d        = run;
  end

  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign O_rgb_de      = de_q;
  assign O_rgb_hsync   = hsync_q;
  assign O_rgb_vsync   = vsync_q;
  assign O_x           = x_q;
  assign O_y           = y_q;
  assign O_line_start  = line_start_q;
  assign O_frame_start = frame_start_q;
  assign O_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 8x6 raster: startup vector table, frame-level
// event counts, reset/enable corner sequences and a randomized run against a frame queue model.
module tb_video_timing_gen;

  localparam int HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [1:0] x;
    logic [1:0] y;
    logic       ls;
    logic       fs;
    logic       busy;
  } out_t;

  typedef struct {
    logic rst;
    logic en;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       I_rst = 1'b1;
  logic       I_enable = 1'b0;
  logic       O_rgb_de, O_rgb_hsync, O_rgb_vsync;
  logic [1:0] O_x, O_y;
  logic       O_line_start, O_frame_start, O_busy;

  int n_vec = 0;
  int n_bad = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .I_rgb_clk    (clk),
    .I_rst        (I_rst),
    .I_enable     (I_enable),
    .O_rgb_de     (O_rgb_de),
    .O_rgb_hsync  (O_rgb_hsync),
    .O_rgb_vsync  (O_rgb_vsync),
    .O_x          (O_x),
    .O_y          (O_y),
    .O_line_start (O_line_start),
    .O_frame_start(O_frame_start),
    .O_busy       (O_busy)
  );

  always #5 clk = ~clk;

  // Reference: each started frame enqueues its 48 output records; enable is only
  // looked at when the queue has drained.
  out_t fq[$];
  out_t exp_o;

  function automatic out_t frame_rec(int k);
    out_t o;
    int col;
    int line;
    col  = k % HT;
    line = k / HT;
    o = '0;
    o.de = (col < HA) && (line < VA);
    o.hs = (col >= HA + HFP) && (col < HA + HFP + HS);
    o.vs = (line >= VA + VFP) && (line < VA + VFP + VS);
    if (o.de) begin
      o.x = 2'(col);
      o.y = 2'(line);
    end
    o.ls = o.de && (col == 0);
    o.fs = o.ls && (line == 0);
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.de = O_rgb_de; o.hs = O_rgb_hsync; o.vs = O_rgb_vsync;
    o.x = O_x; o.y = O_y; o.ls = O_line_start; o.fs = O_frame_start; o.busy = O_busy;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Output-stream statistics and a small line/frame size measurement.
  int st_busy, st_de, st_ls, st_fs, st_hs_fall, st_vs_fall;
  int out_idx, vs_lo, vs_hi;
  int de_run, meas_w, meas_h, ls_in_frame, frames_seen;
  logic prev_hs = 1'b0, prev_vs = 1'b0, prev_de = 1'b0;

  task automatic clear_stats();
    st_busy = 0; st_de = 0; st_ls = 0; st_fs = 0; st_hs_fall = 0; st_vs_fall = 0;
    out_idx = 1000; vs_lo = 1000; vs_hi = -1;
    de_run = 0; meas_w = 0; meas_h = 0; ls_in_frame = 0; frames_seen = 0;
  endtask

  task automatic update_stats();
    if (O_busy) st_busy++;
    if (O_rgb_de) st_de++;
    if (O_line_start) st_ls++;
    if (O_frame_start) st_fs++;
    if (prev_hs && !O_rgb_hsync) st_hs_fall++;
    if (prev_vs && !O_rgb_vsync) st_vs_fall++;
    if (O_frame_start) out_idx = 0; else out_idx++;
    if (O_rgb_vsync) begin
      if (out_idx < vs_lo) vs_lo = out_idx;
      if (out_idx > vs_hi) vs_hi = out_idx;
    end
    if (O_rgb_de) de_run++;
    else begin
      if (prev_de) meas_w = de_run;
      de_run = 0;
    end
    if (O_frame_start) begin
      if (frames_seen >= 1) meas_h = ls_in_frame;
      ls_in_frame = 0;
      frames_seen++;
    end
    if (O_line_start) ls_in_frame++;
    prev_hs = O_rgb_hsync;
    prev_vs = O_rgb_vsync;
    prev_de = O_rgb_de;
  endtask

  task automatic step(input logic rst, input logic en);
    I_rst = rst;
    I_enable = en;
    @(posedge clk);
    if (rst) begin
      fq.delete();
      exp_o = '0;
    end else begin
      exp_o = (fq.size() > 0) ? fq.pop_front() : out_t'('0);
      if (fq.size() == 0 && en)
        for (int k = 0; k < FRAME; k++) fq.push_back(frame_rec(k));
    end
    #1;
    chk("model", int'(dut_out()), int'(exp_o));
    update_stats();
  endtask

  task automatic steps(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en);
  endtask

  vec_t tbl[12];

  task automatic set_row(input int i, input logic rst, input logic en,
                         input logic de, input logic hs, input logic vs,
                         input int x, input int y, input logic ls, input logic fs,
                         input logic busy);
    tbl[i].rst = rst;
    tbl[i].en  = en;
    tbl[i].exp = '{de: de, hs: hs, vs: vs, x: 2'(x), y: 2'(y), ls: ls, fs: fs, busy: busy};
  endtask

  initial begin
    //         i rst en  de hs vs x y ls fs busy
    set_row( 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    set_row( 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    set_row( 2, 0, 0,   1, 0, 0, 0, 0, 1, 1, 1);
    set_row( 3, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);
    set_row( 4, 0, 0,   1, 0, 0, 2, 0, 0, 0, 1);
    set_row( 5, 0, 0,   1, 0, 0, 3, 0, 0, 0, 1);
    set_row( 6, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    set_row( 7, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1);
    set_row( 8, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1);
    set_row( 9, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
    set_row(10, 0, 0,   1, 0, 0, 0, 1, 1, 0, 1);
    set_row(11, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1);

    clear_stats();

    // Reset, then idle with enable low
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    clear_stats();
    steps(20, 1'b0);
    chk("idle_busy_cycles", st_busy, 0);
    chk("idle_de_cycles", st_de, 0);

    // Single-cycle enable pulse: startup table then let the frame finish
    clear_stats();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].en);
      chk($sformatf("table_row%0d", i), int'(dut_out()), int'(tbl[i].exp));
    end
    steps(50, 1'b0);
    chk("pulse_busy_cycles", st_busy, FRAME);
    chk("pulse_de_cycles", st_de, HA * VA);
    chk("pulse_line_starts", st_ls, VA);
    chk("pulse_frame_starts", st_fs, 1);
    chk("pulse_vsync_first", vs_lo, 32);
    chk("pulse_vsync_last", vs_hi, 39);
    chk("pulse_hsync_falls", st_hs_fall, VT);
    chk("pulse_vsync_falls", st_vs_fall, 1);
    chk("pulse_final_busy", int'(O_busy), 0);

    // Enable held: back-to-back frames
    step(1'b0, 1'b1);
    clear_stats();
    steps(3 * FRAME, 1'b1);
    chk("hold_frame_starts", st_fs, 3);
    chk("hold_hsync_falls", st_hs_fall, 3 * VT);
    chk("hold_vsync_falls", st_vs_fall, 3);
    chk("hold_busy_cycles", st_busy, 3 * FRAME);
    steps(60, 1'b0);
    chk("hold_drained_busy", int'(O_busy), 0);

    // Enable dropped mid-frame: the frame still completes in full
    step(1'b0, 1'b1);
    clear_stats();
    steps(10, 1'b1);
    steps(60, 1'b0);
    chk("drop_busy_cycles", st_busy, FRAME);
    chk("drop_de_cycles", st_de, HA * VA);
    chk("drop_frame_starts", st_fs, 1);

    // Reset at frame cycle 20 aborts, then a clean restart
    step(1'b0, 1'b1);
    steps(20, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_busy", int'(O_busy), 0);
    chk("abort_outputs", int'(dut_out()), 0);
    clear_stats();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("restart_frame_start", int'(O_frame_start), 1);
    chk("restart_xy", int'({O_x, O_y}), 0);
    steps(60, 1'b0);
    chk("restart_de_cycles", st_de, HA * VA);
    chk("restart_busy_cycles", st_busy, FRAME);

    // Size measurement from the output stream
    step(1'b0, 1'b1);
    clear_stats();
    steps(2 * FRAME + 4, 1'b1);
    chk("meas_valid", int'(frames_seen >= 2), 1);
    chk("meas_width", meas_w, HA);
    chk("meas_height", meas_h, VA);
    steps(60, 1'b0);

    // Randomized enable with occasional reset
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
